// File: rtl/traffic_phase_arbiter.sv
// Two-road actuated right-of-way arbiter with green/yellow/all-red sequencing and min/max green.
// Optional emergency preemption is compiled in when PREEMPT_EN is defined.
module traffic_phase_arbiter #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned MIN_GREEN = 6,
  parameter int unsigned MAX_GREEN = 9,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned TW        = 4
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  input  logic          req_a,
  input  logic          req_b,
`ifdef PREEMPT_EN
  input  logic          preempt_a,
  input  logic          preempt_b,
`endif
  output logic [2:0]    light_a,
  output logic [2:0]    light_b,
  output logic          pend_a,
  output logic          pend_b,
  output logic [TW-1:0] phase_timer,
  output logic          sec_tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    StGreenA  = 3'd0,
    StYellowA = 3'd1,
    StAllRedA = 3'd2,
    StGreenB  = 3'd3,
    StYellowB = 3'd4,
    StAllRedB = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] phase_timer_q, phase_timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sec_tick_q, sec_tick_d;
  logic          pend_a_q, pend_a_d;
  logic          pend_b_q, pend_b_d;
  logic          req_a_q, req_b_q;

  logic ge_min, ge_max, ge_yel, ge_red, presc_wrap;

  assign ge_min     = phase_timer_q >= TW'(MIN_GREEN);
  assign ge_max     = phase_timer_q >= TW'(MAX_GREEN);
  assign ge_yel     = phase_timer_q >= TW'(YELLOW_T);
  assign ge_red     = phase_timer_q >= TW'(ALLRED_T);
  assign presc_wrap = presc_q == PW'(TICK_DIV - 1);

  // State register
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= StAllRedB;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; preemption bypasses the second tick qualification
  always_comb begin
    state_d = state_q;
    case (state_q)
      StGreenA: begin
`ifdef PREEMPT_EN
        if (preempt_a) state_d = StGreenA;
        else if (preempt_b) state_d = StYellowA;
        else
`endif
        if (sec_tick_q && ((pend_b_q && ge_min) || ge_max)) state_d = StYellowA;
      end
      StYellowA: if (sec_tick_q && ge_yel) state_d = StAllRedA;
      StAllRedA: if (sec_tick_q && ge_red) state_d = StGreenB;
      StGreenB: begin
`ifdef PREEMPT_EN
        if (preempt_a) state_d = StYellowB;
        else if (preempt_b) state_d = StGreenB;
        else
`endif
        if (sec_tick_q && ((pend_a_q && ge_min) || ge_max)) state_d = StYellowB;
      end
      StYellowB: if (sec_tick_q && ge_yel) state_d = StAllRedB;
      StAllRedB: if (sec_tick_q && ge_red) state_d = StGreenA;
      default:   state_d = StAllRedB;
    endcase
  end

  // Lamp decode straight from the state register
  always_comb begin
    light_a = 3'b100;
    light_b = 3'b100;
    case (state_q)
      StGreenA:  light_a = 3'b001;
      StYellowA: light_a = 3'b010;
      StGreenB:  light_b = 3'b001;
      StYellowB: light_b = 3'b010;
      default:   ;
    endcase
  end

  always_comb begin
    presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
    sec_tick_d = presc_wrap;

    if (state_d != state_q) begin
      phase_timer_d = TW'(1);
    end else if (sec_tick_q && (phase_timer_q != '1)) begin
      phase_timer_d = phase_timer_q + TW'(1);
    end else begin
      phase_timer_d = phase_timer_q;
    end

    // Entering a road's green clears its request, overriding a same-cycle edge
    pend_a_d = pend_a_q;
    if (state_d == StGreenA && state_q != StGreenA) begin
      pend_a_d = 1'b0;
    end else if (req_a && !req_a_q && state_q != StGreenA) begin
      pend_a_d = 1'b1;
    end

    pend_b_d = pend_b_q;
    if (state_d == StGreenB && state_q != StGreenB) begin
      pend_b_d = 1'b0;
    end else if (req_b && !req_b_q && state_q != StGreenB) begin
      pend_b_d = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      phase_timer_q <= TW'(1);
      presc_q       <= '0;
      sec_tick_q    <= 1'b0;
      pend_a_q      <= 1'b0;
      pend_b_q      <= 1'b0;
      req_a_q       <= 1'b0;
      req_b_q       <= 1'b0;
    end else begin
      phase_timer_q <= phase_timer_d;
      presc_q       <= presc_d;
      sec_tick_q    <= sec_tick_d;
      pend_a_q      <= pend_a_d;
      pend_b_q      <= pend_b_d;
      req_a_q       <= req_a;
      req_b_q       <= req_b;
    end
  end

  assign pend_a      = pend_a_q;
  assign pend_b      = pend_b_q;
  assign phase_timer = phase_timer_q;
  assign sec_tick    = sec_tick_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Randomized bench for traffic_phase_arbiter against a phase-index reference model.
// Honours PREEMPT_EN the same way as the design.
module tb_traffic_phase_arbiter;

  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned MIN_GREEN = 6;
  localparam int unsigned MAX_GREEN = 9;
  localparam int unsigned YELLOW_T  = 2;
  localparam int unsigned ALLRED_T  = 2;
  localparam int unsigned TW        = 4;
  localparam int          TMAX      = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_a, req_b;
  logic          pa, pb;
  logic [2:0]    light_a, light_b;
  logic          pend_a, pend_b;
  logic [TW-1:0] phase_timer;
  logic          sec_tick;

  traffic_phase_arbiter #(
    .TICK_DIV (TICK_DIV),
    .MIN_GREEN(MIN_GREEN),
    .MAX_GREEN(MAX_GREEN),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T),
    .TW       (TW)
  ) u_dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef PREEMPT_EN
    .preempt_a  (pa),
    .preempt_b  (pb),
`endif
    .light_a    (light_a),
    .light_b    (light_b),
    .pend_a     (pend_a),
    .pend_b     (pend_b),
    .phase_timer(phase_timer),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: phase index 0..5 = GA, YA, RA, GB, YB, RB; road = phase/3
  int m_phase, m_timer, m_k;
  bit m_tick;
  bit m_pend[2];
  bit m_prev[2];

  function automatic logic [2:0] lamp(input int phase, input int road);
    if (phase == 3 * road) return 3'b001;
    if (phase == 3 * road + 1) return 3'b010;
    return 3'b100;
  endfunction

  task automatic model_step(input bit rst, input bit ra, input bit rb, input bit ppa,
                            input bit ppb);
    bit req[2];
    int road, sub, other, nphase;
    bit ex, hold;
    if (rst) begin
      m_phase = 5; m_timer = 1; m_k = 0; m_tick = 0;
      m_pend[0] = 0; m_pend[1] = 0; m_prev[0] = 0; m_prev[1] = 0;
      return;
    end
    req[0] = ra; req[1] = rb;
    road  = m_phase / 3;
    sub   = m_phase % 3;
    other = 1 - road;
    ex    = 0;
    hold  = 0;
`ifdef PREEMPT_EN
    if (sub == 0) begin
      if (road == 0) begin
        if (ppa) hold = 1; else if (ppb) ex = 1;
      end else begin
        if (ppa) ex = 1; else if (ppb) hold = 1;
      end
    end
`else
    if (ppa || ppb) hold = 0;
`endif
    if (!hold && !ex && m_tick) begin
      case (sub)
        0: ex = (m_pend[other] && m_timer >= int'(MIN_GREEN)) || m_timer >= int'(MAX_GREEN);
        1: ex = m_timer >= int'(YELLOW_T);
        default: ex = m_timer >= int'(ALLRED_T);
      endcase
    end
    nphase = ex ? (m_phase + 1) % 6 : m_phase;
    if (ex) m_timer = 1;
    else if (m_tick) m_timer = (m_timer < TMAX) ? m_timer + 1 : TMAX;
    for (int r = 0; r < 2; r++) begin
      if (nphase == 3 * r && m_phase != 3 * r) m_pend[r] = 0;
      else if (req[r] && !m_prev[r] && m_phase != 3 * r) m_pend[r] = 1;
      m_prev[r] = req[r];
    end
    m_tick  = ((m_k + 1) % TICK_DIV) == 0;
    m_k++;
    m_phase = nphase;
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    pa    = 1'b0;
    pb    = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      model_step(reset, req_a, req_b, pa, pb);
      @(negedge clk);
      check_eq("light_a", 32'(light_a), 32'(lamp(m_phase, 0)));
      check_eq("light_b", 32'(light_b), 32'(lamp(m_phase, 1)));
      check_eq("pend_a", 32'(pend_a), 32'(m_pend[0]));
      check_eq("pend_b", 32'(pend_b), 32'(m_pend[1]));
      check_eq("phase_timer", 32'(phase_timer), 32'(m_timer));
      check_eq("sec_tick", 32'(sec_tick), 32'(m_tick));
      // Drive next-cycle stimulus away from the active edge
      reset = (cyc < 1) || ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 19) == 0) req_a = ~req_a;
      if ($urandom_range(0, 19) == 0) req_b = ~req_b;
`ifdef PREEMPT_EN
      if ($urandom_range(0, 149) == 0) pa = ~pa;
      if ($urandom_range(0, 149) == 0) pb = ~pb;
`endif
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
